mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for a shared 4-to-1 data multiplexer. Four requesters compete for one output path. The block grants one owner at a time and drives the 2-bit mux select. It also registers the selected data word onto a single output bus. It sits between the requester interfaces and the downstream consumer of the muxed path.

## Interface
- `DATA_W`, default 8: width of each requester data word and of `data_out`.
- `MAX_BURST`, default 8: maximum consecutive grant cycles per owner. Used only when `MUX4_ARB_BURST_LIMIT_EN` is defined. Legal range 2..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `done`  in  1  current owner finishing; sampled only while `busy`=1.
- `data_in`  in  4*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- `grant`  out  4  one-hot registered grant, or all zero.
- `sel`  out  2  registered mux select; equals the index of the granted requester.
- `busy`  out  1  high while any grant is held.
- `data_out`  out  DATA_W  registered selected data.
- `out_valid`  out  1  high when `data_out` holds owner data.

## Operation
- Two-state FSM: IDLE and GRANT.
- Rotating priority pointer `ptr` (2 bits). Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- **IDLE:**
  - If `req` is nonzero, choose the first set bit in search order.
  - Set `grant` to one-hot of the winner, set `sel` to the winner index, set `busy`=1, go to GRANT.
  - Otherwise hold all outputs at zero.
- **GRANT:** the owner keeps the grant while `req[sel]`=1 and `done`=0.
- **Release:** triggered by `done`=1, by `req[sel]`=0, or by a burst-limit hit. On release:
  - `ptr` becomes `sel`+1, wrapping 3 to 0.
  - Requests from the other requesters are searched from the new `ptr`, excluding the releasing owner.
  - If any is found, the new grant is loaded on the same edge. There is no bubble.
  - If none is found, `grant` becomes 0, `busy` becomes 0, and the FSM returns to IDLE.
  - The releasing owner can only win again after an IDLE cycle.
- Requests from non-owners during GRANT are ignored until release. There is no preemption except the burst limit.
- **Data path:**
  - Each cycle, `data_out` is loaded with `data_in` word[`sel`] if `busy`=1, else with 0.
  - `out_valid` is loaded with `busy`.
- `grant` is never multi-hot.
- `sel` holds its last value while IDLE. It is not used while IDLE.

## Timing
- Reset values: `grant`=0, `sel`=0, `busy`=0, `data_out`=0, `out_valid`=0, `ptr`=0, FSM in IDLE, burst counter=0.
- Asserting `rst_n`=0 in mid-grant clears everything immediately, without waiting for a clock edge.
- Request latency: `req` high before edge N gives `grant` and `busy` valid after edge N. That is 1 cycle.
- Data latency: `data_out` and `out_valid` trail `grant` by one cycle.
- Release latency: `done` sampled at edge N means the grant is dropped or handed off after edge N.
- Simultaneous `done` and a new request from the same owner: release wins, and the owner is excluded from the handoff.
- `done` while IDLE is ignored.
- Wrap-around: owner 3 releasing sets `ptr`=0.

## Configuration
- Macro: `MUX4_ARB_BURST_LIMIT_EN`.
- **Defined:**
  - An 8-bit counter clears on every new grant and increments each GRANT cycle.
  - When the counter equals `MAX_BURST`-1 and any other requester is asserting `req`, the grant is released on that edge as a normal release.
  - If no other requester is asserting `req`, the counter saturates and the owner keeps the grant.
- **Undefined:** there is no counter, and an owner can hold the grant indefinitely.

## Structure
- Shared package `mux4_arb_pkg` holds:
  - state encoding constants `ST_IDLE`=0 and `ST_GRANT`=1;
  - `NUM_REQ`=4 and `IDX_W`=2.
- One sub-module, `rr_pick4`: a combinational round-robin picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`.
  - Outputs: `found`, `idx[1:0]`.
  - It is shared by the IDLE and release paths.
- The FSM, registers and data mux stay in the top module.

## Test plan
- Reset then `req`=4'b0100 → after 1 edge `grant`=4'b0100, `sel`=2; one edge later `data_out` equals word 2 and `out_valid`=1.
- `req`=4'b1111 held, owner pulses `done` each cycle → grants rotate 0,1,2,3,0 with no idle cycles.
- Owner 3 holding, `req`=4'b1001, `done`=1 → next grant is 0, `ptr` wraps to 0, and 3 is excluded.
- Single requester 1 drops `req` with no others pending → `busy`=0, `grant`=0 next edge; `out_valid`=0 one edge after that.
- With the macro defined and `MAX_BURST`=4: requester 0 holds while `req[2]`=1 → grant switches to 2 after exactly 4 grant cycles. With no competitor, 0 holds for 20+ cycles.
- `rst_n` pulsed low mid-grant, between clock edges → all outputs are 0 immediately; after release, `req`=4'b0011 grants 0 first.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: FSM states,
// requester count/index width and a one-hot helper.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or after ptr,
// searching ptr, ptr+1, ptr+2, ptr+3 modulo 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] cand_req;
  logic [1:0] cand;

  always_comb begin
    cand_req = req & ~mask;
    found    = 1'b0;
    idx      = ptr;
    cand     = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && cand_req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-to-1 data mux with registered
// grant, select and data. Optional burst limit: define MUX4_ARB_BURST_LIMIT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic                  done,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            grant,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [DATA_W-1:0]     data_out,
  output logic                  out_valid
);

  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_d;
  logic [1:0] sel_d;
  logic       busy_d;
  logic       new_grant;
  logic       release_now;
  logic       burst_hit;
  logic [3:0] owner_oh;

  logic [1:0] pick_ptr;
  logic [3:0] pick_mask;
  logic       pick_found;
  logic [1:0] pick_idx;

  // One picker serves both paths: IDLE searches from ptr with nothing masked,
  // a release searches from sel+1 with the outgoing owner masked.
  always_comb begin
    owner_oh  = onehot4(sel);
    pick_ptr  = ptr_q;
    pick_mask = '0;
    if (state_q == ST_GRANT) begin
      pick_ptr  = sel + 2'd1;
      pick_mask = owner_oh;
    end
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX4_ARB_BURST_LIMIT_EN
  logic [7:0] burst_q;

  always_comb begin
    burst_hit = (burst_q == 8'(MAX_BURST - 1)) && (|(req & ~owner_oh));
  end

  // Saturates at MAX_BURST-1 so a lone owner keeps the grant until a rival shows up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else if (new_grant) begin
      burst_q <= '0;
    end else if (state_q == ST_GRANT && burst_q != 8'(MAX_BURST - 1)) begin
      burst_q <= burst_q + 8'd1;
    end
  end
`else
  always_comb begin
    burst_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant;
    sel_d       = sel;
    busy_d      = busy;
    new_grant   = 1'b0;
    release_now = done || !req[sel] || burst_hit;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d   = onehot4(pick_idx);
          sel_d     = pick_idx;
          busy_d    = 1'b1;
          new_grant = 1'b1;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_d = sel + 2'd1;
          if (pick_found) begin
            grant_d   = onehot4(pick_idx);
            sel_d     = pick_idx;
            new_grant = 1'b1;
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant     <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant     <= grant_d;
      sel       <= sel_d;
      busy      <= busy_d;
      data_out  <= busy ? data_in[int'(sel)*DATA_W +: DATA_W] : '0;
      out_valid <= busy;
    end
  end

endmodule
